// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM behind valid/ready request/response channels with
// programmable latency, byte/half/word sizing, load extension and fault detection.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        cap_we;
  logic [31:0] cap_addr;
  logic [1:0]  cap_size;
  logic        cap_uns;
  logic [31:0] cap_wdata;

  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] word_idx;
  logic          err;
  logic          mem_we;
  logic [31:0]   cur_word;
  logic [31:0]   new_word;
  logic [31:0]   load_data;
  logic [31:0]   shifted;
  logic [31:0]   lane_data;
  logic [3:0]    lane_mask;

  assign word_idx = cap_addr[AW+1:2];
  assign cur_word = mem[word_idx];
  assign mem_we   = (state == WAIT) && (cnt == 4'd0) && cap_we && !err;

  // Fault decode on the captured request
  always_comb begin
    err = (cap_addr[31:2] >= 30'(DEPTH_WORDS));
    case (cap_size)
      2'b00:   err = err;
      2'b01:   err = err | cap_addr[0];
      2'b10:   err = err | (|cap_addr[1:0]);
      default: err = 1'b1;
    endcase
  end

  // Store merge: replicate data across lanes, then keep only the addressed ones
  always_comb begin
    lane_mask = 4'b0000;
    lane_data = cap_wdata;
    new_word  = cur_word;
    case (cap_size)
      2'b00: begin
        lane_mask = 4'b0001 << cap_addr[1:0];
        lane_data = {4{cap_wdata[7:0]}};
      end
      2'b01: begin
        lane_mask = cap_addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{cap_wdata[15:0]}};
      end
      2'b10:   lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
    for (int k = 0; k < 4; k++) begin
      if (lane_mask[k]) new_word[8*k +: 8] = lane_data[8*k +: 8];
    end
  end

  // Load path: right-align the addressed lanes and extend
  always_comb begin
    shifted = cur_word >> {cap_addr[1:0], 3'b000};
    case (cap_size)
      2'b00:   load_data = {{24{~cap_uns & shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = {{16{~cap_uns & shifted[15]}}, shifted[15:0]};
      default: load_data = cur_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[word_idx] <= new_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      cap_we    <= 1'b0;
      cap_addr  <= 32'd0;
      cap_size  <= 2'b00;
      cap_uns   <= 1'b0;
      cap_wdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          if (req_valid && req_ready) begin
            cap_we    <= req_we;
            cap_addr  <= req_addr;
            cap_size  <= req_size;
            cap_uns   <= req_unsigned;
            cap_wdata <= req_wdata;
            cnt       <= 4'(LATENCY - 1);
            req_ready <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          req_ready <= 1'b0;
          if (cnt == 4'd0) begin
            rsp_valid <= 1'b1;
            rsp_err   <= err;
            rsp_rdata <= (err || cap_we) ? 32'd0 : load_data;
            state     <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          req_ready <= 1'b0;
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder (slave side) for the core's load/store port: a word-organised RAM behind a valid/ready request channel and a valid/ready response channel.
- Adds the programmable access latency, byte/halfword/word sizing and load sign/zero extension that the multi-cycle and pipelined cores need for lb/lbu/lh/lhu/sb/sh/lw/sw.
- Holds one outstanding transaction at a time.
- Sits between the core's load/store unit and the data RAM inside top.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words stored; word index = req_addr[31:2].
LATENCY, 2, cycles from request acceptance to response valid; legal range 1..15.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  responder can accept a request this cycle.
req_we  input  1  1 = store, 0 = load.
req_addr  input  32  byte address.
req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
req_unsigned  input  1  loads only: 1 = zero-extend (lbu/lhu), 0 = sign-extend.
req_wdata  input  32  store data, right-aligned: byte in [7:0], half in [15:0].
rsp_valid  output  1  response present.
rsp_ready  input  1  core accepts response.
rsp_rdata  output  32  load result, right-aligned and extended; 0 for stores and errors.
rsp_err  output  1  access faulted: misaligned, illegal size or out of range.

Behaviour:
- States: IDLE, WAIT, RESP. A 4-bit latency counter runs in WAIT.
- Reset (async, any state):
  - State goes to IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0; counter=0.
  - req_ready=0 while reset is high.
  - RAM contents are not reset. Benches preload RAM hierarchically.
- IDLE:
  - req_ready=1, rsp_valid=0.
  - On an edge with req_valid&req_ready: capture we/addr/size/unsigned/wdata, load counter with LATENCY-1, go to WAIT.
- WAIT:
  - req_ready=0.
  - Each edge: if counter==0, perform the access and go to RESP; else decrement the counter.
  - Net effect: a request accepted at edge N produces rsp_valid=1 after edge N+LATENCY. A store commits to RAM at edge N+LATENCY.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are registered and stable until the handshake.
  - req_ready=0.
  - On an edge with rsp_ready=1: go to IDLE and drop rsp_valid.
  - Back-to-back: the next request can be accepted at the earliest one cycle after the response handshake. There is no same-cycle turnaround.
- Error detection, evaluated on captured fields:
  - size=11 is an error.
  - size=01 with addr[0]=1 is an error.
  - size=10 with addr[1:0]!=00 is an error.
  - addr[31:2] >= DEPTH_WORDS is an error.
  - On error: rsp_err=1, rsp_rdata=0, and RAM is not modified.
- Byte ordering:
  - Little-endian; lane k = word bits [8k+7:8k].
  - Byte: lane = addr[1:0].
  - Half: lanes addr[1]*2 and addr[1]*2+1.
- Stores: read-modify-write of only the addressed lanes; other lanes are unchanged. rsp_rdata=0, rsp_err=0.
- Loads:
  - Select the addressed lanes and right-align them.
  - Extend from bit 7 (byte) or bit 15 (half) with the sign bit unless req_unsigned=1, in which case zero-fill.
  - Word loads ignore req_unsigned.
- Input stability: inputs are sampled only at acceptance. Changes to req_* while in WAIT or RESP have no effect.
- rsp_ready held high while in IDLE or WAIT has no effect.
- Reset mid-operation: a store in WAIT whose counter has not expired is dropped; RAM is unchanged. A response pending in RESP is discarded.

Test Plan:
- Word round trip, LATENCY=2:
  - sw addr 0x64 wdata 0x00000019, accepted edge N → rsp_valid after N+2, rsp_err=0, rsp_rdata=0.
  - Then lw 0x64 → rsp_rdata=0x00000019.
- Byte lanes: preload word 0 = 0x11223344; sb addr 0x2 wdata 0xAB → word 0 = 0x11AB3344. Then:
  - lb 0x2 → 0xFFFFFFAB.
  - lbu 0x2 → 0x000000AB.
  - lb 0x0 → 0x00000044.
- Halfword: preload word 1 = 0x8001_7FFE. Then:
  - lh 0x6 → 0xFFFF8001.
  - lhu 0x6 → 0x00008001.
  - lh 0x4 → 0x00007FFE.
  - sh 0x4 wdata 0x1234 → word 1 = 0x80011234.
- Errors, each with rsp_err=1, rsp_rdata=0 and RAM unchanged:
  - lw 0x65.
  - sh 0x3.
  - size=11.
  - sw to addr 0x400 with DEPTH_WORDS=256.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid → rsp_valid, rsp_rdata and rsp_err stay stable, and req_ready=0 throughout. Raise rsp_ready → IDLE next cycle, req_ready=1.
- Reset and latency sweep:
  - Assert reset during WAIT of sw 0x10 wdata 0xDEADBEEF → rsp_valid=0 immediately and word 4 keeps its old value.
  - Repeat the round-trip test with LATENCY=1 and LATENCY=15; response must arrive exactly LATENCY edges after acceptance.
